// File: rtl/iob_rom_reader.sv
// -----------------------------------------------------------------------------
// iob_rom_reader
// Streams a run of consecutive words out of a synchronous ROM (1-cycle
// registered read) onto a valid/ready stream. A start pulse in IDLE latches a
// start address and a word count. Reads are then issued with back-pressure
// awareness into a 2-entry in-order buffer, which feeds the stream output.
// The address wraps modulo the ROM depth.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           request pulse, honoured only in IDLE
//   start_addr      first ROM address (sampled with start)
//   len             word count 0..2**ADDR_W (sampled with start)
//   busy            high in every state except IDLE
//   done            one-cycle pulse when a transfer finishes
//   rom_r_en        ROM read enable
//   rom_addr        ROM read address
//   rom_r_data      ROM read data, valid the cycle after rom_r_en
//   m_data          stream data (registered)
//   m_valid         stream valid
//   m_ready         stream ready from the sink
//   m_last          marks the final beat of a transfer
// -----------------------------------------------------------------------------
module iob_rom_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rom_r_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_r_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]   issue_cnt;      // reads still to be issued
  logic [ADDR_W-1:0] addr_q;         // address of the next read
  logic              in_flight;      // a read was issued last cycle
  logic              in_flight_last; // ... and it was the final one

  // Two-entry buffer: head drives the stream, skid holds one more word.
  logic [DATA_W-1:0] head_data, skid_data;
  logic              head_valid, head_last;
  logic              skid_valid, skid_last;

  logic       pop;
  logic       issue;
  logic       last_issue;
  logic       load;
  logic [2:0] tally;

  assign pop = head_valid & m_ready;

  // Occupancy after this cycle if a read were issued now. A read is only
  // allowed when its returning word is guaranteed a buffer slot.
  assign tally = {2'b00, head_valid} + {2'b00, skid_valid}
               + {2'b00, in_flight} + 3'd1;

  assign issue      = (state == S_READ) && (issue_cnt != '0)
                      && (tally <= (3'd2 + {2'b00, pop}));
  assign last_issue = issue && (issue_cnt == (ADDR_W+1)'(1));
  assign load       = (state == S_IDLE) && start && (len != '0);

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_nxt; no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (len == '0) ? S_DONE : S_READ;
      S_READ:  if (last_issue) state_nxt = S_FLUSH;
      S_FLUSH: if (pop && head_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Address / issue counter and in-flight tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      issue_cnt      <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      if (load) begin
        addr_q    <= start_addr;
        issue_cnt <= len;
      end else if (issue) begin
        addr_q    <= addr_q + 1'b1;  // wraps naturally at 2**ADDR_W
        issue_cnt <= issue_cnt - 1'b1;
      end
      in_flight      <= issue;
      in_flight_last <= last_issue;
    end
  end

  // ---------------------------------------------------------------------------
  // In-order 2-entry buffer. The issue throttle guarantees a returning word
  // never finds both slots occupied without a pop in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data  <= '0;
      head_valid <= 1'b0;
      head_last  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        head_data  <= skid_data;
        head_last  <= skid_last;
        head_valid <= 1'b1;
        if (in_flight) begin
          skid_data <= rom_r_data;
          skid_last <= in_flight_last;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (in_flight) begin
        head_data  <= rom_r_data;
        head_last  <= in_flight_last;
        head_valid <= 1'b1;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (in_flight) begin
      if (!head_valid) begin
        head_data  <= rom_r_data;
        head_last  <= in_flight_last;
        head_valid <= 1'b1;
      end else begin
        skid_data  <= rom_r_data;
        skid_last  <= in_flight_last;
        skid_valid <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign rom_r_en = issue;
  assign rom_addr = addr_q;
  assign m_data   = head_data;
  assign m_valid  = head_valid;
  assign m_last   = head_valid & head_last;  // stale flag masked once drained

endmodule

// File: tb/tb_iob_rom_reader.sv
// -----------------------------------------------------------------------------
// Testbench for iob_rom_reader. ROM model: 1-cycle registered read with
// ROM[i] = i + 32. Stimulus pushes expected beats into a queue; a monitor
// pops and compares on every accepted beat.
// -----------------------------------------------------------------------------
module tb_iob_rom_reader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   len;
  logic              busy, done, rom_r_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_r_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_ready, m_last;

  iob_rom_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .rom_r_en   (rom_r_en),
    .rom_addr   (rom_addr),
    .rom_r_data (rom_r_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  // ROM model
  always_ff @(posedge clk) begin
    if (rom_r_en) rom_r_data <= 8'(rom_addr) + 8'd32;
  end

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [8:0] exp_q[$];   // {last, data}
  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_pop_cyc = 0;
  int en_cnt = 0;
  int valid_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_expected(input int a, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == n - 1), 8'(((a + k) % 16) + 32)});
  endtask

  task automatic monitor();
    logic       hold = 1'b0;
    logic [7:0] hold_data = '0;
    int         outstanding = 0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        outstanding = 0;
      end else begin
        if (hold) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", 32'(m_data), 32'(hold_data));
        end
        if (outstanding + int'(rom_r_en) - int'(m_valid && m_ready) > 2) begin
          check("occupancy_le_2", 32'(outstanding + int'(rom_r_en)), 32'd2);
        end
        outstanding += int'(rom_r_en) - int'(m_valid && m_ready);
        hold = m_valid && !m_ready;
        hold_data = m_data;
      end
      if (rom_r_en) en_cnt++;
      if (m_valid) valid_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(m_data), 32'(e[7:0]));
          check("beat_last", 32'(m_last), 32'(e[8]));
          if (m_last) last_pop_cyc = cyc;
        end
      end
    end
  endtask

  // Drive a start pulse; returns #1 into cycle C1.
  task automatic do_start(input int a, input int n, input bit expect_beats);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = ADDR_W'(a);
    len = (ADDR_W+1)'(n);
    if (expect_beats) push_expected(a, n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int base = done_cnt;
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt != base) break;
    end
    if (i == budget) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [31:0] pat;
  int base_done, base_pop, t_first, i;

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b1;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset_outputs",
          {19'd0, busy, done, rom_r_en, m_valid, m_last, rom_addr, m_data},
          32'd0);

    // Full ROM sweep, m_ready held high: latency and throughput
    base_pop = pop_cnt;
    do_start(0, 16, 1'b1);
    @(negedge clk);
    check("c1_rom_r_en", 32'(rom_r_en), 32'd1);
    check("c1_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    check("c2_m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("c3_m_valid", 32'(m_valid), 32'd1);
    check("c3_m_data", 32'(m_data), 32'h20);
    t_first = cyc;
    wait_done("sweep", 60);
    check("sweep_span", 32'(last_pop_cyc - t_first), 32'd15);
    check("sweep_done_cycle", 32'(done_cyc - last_pop_cyc), 32'd1);
    check("sweep_beats", 32'(pop_cnt - base_pop), 32'd16);
    @(negedge clk);
    check("sweep_busy_after", 32'(busy), 32'd0);

    // Address wrap
    base_pop = pop_cnt;
    do_start(14, 4, 1'b1);
    wait_done("wrap", 40);
    check("wrap_beats", 32'(pop_cnt - base_pop), 32'd4);
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero length: done in C1, no read, no beat
    base_done = done_cnt;
    en_cnt = 0;
    valid_cnt = 0;
    do_start(5, 0, 1'b0);
    @(negedge clk);
    check("len0_done_c1", 32'(done), 32'd1);
    repeat (4) @(negedge clk);
    check("len0_done_count", 32'(done_cnt - base_done), 32'd1);
    check("len0_no_read", 32'(en_cnt), 32'd0);
    check("len0_no_valid", 32'(valid_cnt), 32'd0);

    // Back-pressure with a fixed irregular m_ready pattern
    pat = 32'b1011_0010_0110_1101_0001_1100_1010_0111;
    base_pop = pop_cnt;
    base_done = done_cnt;
    do_start(3, 6, 1'b1);
    for (i = 0; i < 200; i++) begin
      m_ready = pat[i % 32];
      @(posedge clk); #1;
      if (done_cnt != base_done) break;
    end
    if (i == 200) check("bp_timeout", 32'd0, 32'd1);
    m_ready = 1'b1;
    check("bp_beats", 32'(pop_cnt - base_pop), 32'd6);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a transfer
    base_done = done_cnt;
    base_pop = pop_cnt;
    do_start(0, 10, 1'b1);
    for (i = 0; i < 40; i++) begin
      if (pop_cnt - base_pop >= 3) break;
      @(posedge clk); #1;
    end
    if (i == 40) check("abort_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("abort_outputs",
          {19'd0, busy, done, rom_r_en, m_valid, m_last, rom_addr, m_data},
          32'd0);
    base_pop = pop_cnt;
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    check("abort_no_beat", 32'(pop_cnt - base_pop), 32'd0);
    do_start(0, 2, 1'b1);
    wait_done("after_abort", 30);
    check("after_abort_beats", 32'(pop_cnt - base_pop), 32'd2);

    // Start while busy is ignored
    base_done = done_cnt;
    base_pop = pop_cnt;
    do_start(8, 5, 1'b1);
    start = 1'b1; start_addr = 4'd0; len = 5'd2;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done("busy_start", 40);
    repeat (6) @(negedge clk);
    check("busy_start_done_count", 32'(done_cnt - base_done), 32'd1);
    check("busy_start_beats", 32'(pop_cnt - base_pop), 32'd5);
    check("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);
    check("busy_start_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
